instruction_fetch_unit: RTL

Initiator side of the instruction-memory read interface. Owns the fetch PC and issues one word read at a time. Waits on the memory's BUSYWAIT and pushes each returned {PC, instruction} pair into a small prefetch FIFO that feeds the IF/ID stage. Handles decode back-pressure and branch/jump redirects, including redirects that arrive while a read is in flight.

---
 rtl/instruction_fetch_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch initiator: one outstanding word read at a time, results
// buffered in a show-ahead prefetch FIFO; redirects flush and refetch.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READINST,
  input  logic        IMEM_BUSYWAIT,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  input  logic        STALL,
  output logic        INST_VALID,
  output logic [31:0] INST,
  output logic [31:0] INST_PC
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]       r_state;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_addr;
  logic             r_read;
  logic             r_discard;
  logic [31:0]      r_pc_mem   [BUF_DEPTH];
  logic [31:0]      r_inst_mem [BUF_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic        w_complete;
  logic        w_in_flight;
  logic        w_can_issue;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_redirect_pc;

  assign w_complete    = (r_state == S_WAIT) && !IMEM_BUSYWAIT;
  assign w_in_flight   = (r_state == S_ISSUE) || ((r_state == S_WAIT) && IMEM_BUSYWAIT);
  assign w_can_issue   = (r_count < CNT_W'(BUF_DEPTH)) && !REDIRECT;
  assign w_push        = w_complete && !r_discard && !REDIRECT;
  assign w_pop         = INST_VALID && !STALL;
  assign w_redirect_pc = REDIRECT_PC & ~32'h3;

  assign IMEM_READ    = r_read;
  assign IMEM_ADDRESS = r_addr;
  assign INST_VALID   = (r_count != '0);
  assign INST         = r_inst_mem[r_rptr];
  assign INST_PC      = r_pc_mem[r_rptr];

  // Memory-side FSM; IDLE between reads lets the memory re-arm BUSYWAIT.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_read     <= 1'b0;
      r_discard  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_can_issue) begin
            r_state <= S_ISSUE;
            r_addr  <= r_fetch_pc;
            r_read  <= 1'b1;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (!IMEM_BUSYWAIT) begin
            r_state <= S_IDLE;
            r_read  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_read  <= 1'b0;
        end
      endcase

      // An in-flight read cannot be aborted, so its data is marked for dropping.
      if (REDIRECT) begin
        r_fetch_pc <= w_redirect_pc;
        if (w_in_flight)
          r_discard <= 1'b1;
        else if (w_complete)
          r_discard <= 1'b0;
      end else if (w_complete) begin
        if (r_discard)
          r_discard <= 1'b0;
        else
          r_fetch_pc <= r_fetch_pc + 32'd4;
      end
    end
  end

  // Prefetch FIFO; a redirect empties it and suppresses same-edge push/pop.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (REDIRECT) begin
      r_wptr  <= r_rptr;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wptr]   <= r_addr;
        r_inst_mem[r_wptr] <= IMEM_READINST;
        r_wptr             <= r_wptr + PTR_W'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
